awg_cmd_ctrl: RTL
=================

Name: awg_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the DDS/waveform datapath.
- Decodes single-byte waveform-select commands.
- Decodes multi-byte parameter commands: 'F'/'A'/'P' + decimal digits + CR.
- Holds and publishes waveform select, frequency word, amplitude and phase, with a one-cycle update strobe when any field changes.

Parameters:
- FREQ_W, 14, width of frequency word output.
- AMP_W, 8, width of amplitude output.
- PH_W, 8, width of phase output.
- MAX_DIGITS, 5, maximum decimal digits accepted per parameter command.
- TIMEOUT_CYCLES, 50000000, idle cycles before a partial command is abandoned (CMD_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_data  in  8  received ASCII byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
- wave_sel  out  5  waveform select.
- freq_word  out  FREQ_W  DDS frequency word.
- amp  out  AMP_W  amplitude scale.
- phase  out  PH_W  phase offset.
- cfg_update  out  1  one-cycle pulse, cycle after any output field is written.
- cmd_err  out  1  one-cycle pulse on a malformed command.
- busy  out  1  high while a parameter command is in progress (state != IDLE).

Behaviour:
- Interfaces: one clock; reset is synchronous and active-high; ports named clk and rst.
- Reset values: wave_sel=3, freq_word=1, amp=2^AMP_W-1, phase=0, cfg_update=0, cmd_err=0, busy=0, FSM=IDLE, accumulator=0, digit count=0.
- Bytes are consumed only on cycles where rx_valid=1; all other cycles hold state.
- FSM states: IDLE, DIGITS, APPLY.
- IDLE transitions:
  - '1'/'2'/'3'/'4' (49..52): wave_sel<=0/1/2/3.
  - '0' (48): wave_sel<=10.
  - For these five bytes, cfg_update pulses on the next cycle and the FSM stays in IDLE.
  - 'F'(70), 'A'(65), 'P'(80): latch target field, clear accumulator and digit count, go to DIGITS.
  - Any other byte is ignored silently; no error, no update.
- DIGITS transitions:
  - '0'..'9': acc<=min(acc*10+digit, field_max); count++.
  - A digit arriving while count==MAX_DIGITS: cmd_err, go to IDLE, no field change.
  - CR (13) with count>=1: go to APPLY.
  - CR with count==0: cmd_err, go to IDLE.
  - ESC (27): go to IDLE silently.
  - Any other byte: cmd_err, go to IDLE.
- APPLY: single cycle, no byte consumed.
  - Write acc into the target field; cfg_update=1 during APPLY; next state IDLE.
  - An rx_valid byte arriving during APPLY is processed as if in IDLE, in the same cycle.
- field_max values: freq 2^FREQ_W-1, amp 2^AMP_W-1, phase 2^PH_W-1.
  - Accumulator is 17 bits internally; saturates at field_max and never wraps.
- Latencies:
  - Single-byte command: output changes on the clock edge after rx_valid; cfg_update is high in that same following cycle.
  - Parameter command: field is visible 2 cycles after the CR strobe.
- rst mid-command: abandons the partial command; all outputs return to reset values; no cmd_err.
- cmd_err and cfg_update are never high in the same cycle.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- With macro:
  - Counter clears on every rx_valid and runs while in DIGITS.
  - When the count reaches TIMEOUT_CYCLES: cmd_err pulses once, FSM goes to IDLE, no field change.
  - Counter held at 0 in IDLE.
- Without macro: no counter; DIGITS waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package awg_cmd_pkg contains:
  - ASCII constants: CH_0, CH_9, CH_F, CH_A, CH_P, CH_CR, CH_ESC.
  - FSM state encoding.
  - Target-field enum: FLD_FREQ/FLD_AMP/FLD_PHASE.
  - Reset defaults: WAVE_DEF=3, FREQ_DEF=1.
  - Waveform code for '0': WAVE_OFF=10.
- Sub-module awg_dec_accum:
  - Saturating decimal accumulator with inputs clr, digit_valid, digit[3:0], max.
  - Outputs acc and count.
- Top level holds the FSM, output registers, strobes and the optional timeout counter.

Test Plan:
- Reset then idle 10 cycles -> wave_sel=3, freq_word=1, amp=255, phase=0, busy=0, no strobes.
- Bytes '2','0' separated by 3 cycles -> wave_sel=1 then 10; cfg_update pulses twice, 1 cycle after each byte.
- "F1234\r" -> freq_word=1234 two cycles after CR; busy high from 'F' until APPLY; single cfg_update.
- "A999\r" and "F99999\r" -> amp=255 and freq_word=16383 (saturated); no cmd_err.
- Error and abort cases:
  - "F\r" -> cmd_err pulse, freq unchanged.
  - "P12x" -> cmd_err, phase unchanged.
  - "P12"+ESC -> no error, phase unchanged.
  - "F123456" -> cmd_err on 6th digit.
- Mid-command reset and timeout:
  - rst asserted after "A12" -> all reset values; subsequent "\r" ignored in IDLE.
  - With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: "A5" then silence -> cmd_err at cycle 100, amp unchanged.

Source files
------------

// File: rtl/awg_cmd_pkg.sv
// Shared constants, state and field encodings for the AWG command sequencer.
// Optional idle-timeout abort is enabled by defining CMD_TIMEOUT_EN.
package awg_cmd_pkg;

    localparam logic [7:0] CH_0   = 8'd48;
    localparam logic [7:0] CH_1   = 8'd49;
    localparam logic [7:0] CH_4   = 8'd52;
    localparam logic [7:0] CH_9   = 8'd57;
    localparam logic [7:0] CH_F   = 8'd70;
    localparam logic [7:0] CH_A   = 8'd65;
    localparam logic [7:0] CH_P   = 8'd80;
    localparam logic [7:0] CH_CR  = 8'd13;
    localparam logic [7:0] CH_ESC = 8'd27;

    localparam int ACC_W = 17;

    localparam logic [4:0] WAVE_DEF = 5'd3;
    localparam logic [4:0] WAVE_OFF = 5'd10;
    localparam int         FREQ_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIGITS,
        ST_APPLY
    } state_t;

    typedef enum logic [1:0] {
        FLD_FREQ,
        FLD_AMP,
        FLD_PHASE
    } fld_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/awg_cmd_ctrl_accum.sv
// Saturating decimal accumulator: acc = min(acc*10 + digit, max), plus digit count.
// Used by awg_cmd_ctrl (CMD_TIMEOUT_EN does not affect this block).
module awg_dec_accum
    import awg_cmd_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic [ACC_W-1:0] max,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] count
);

    localparam int WIDE_W = ACC_W + 4;

    logic [WIDE_W-1:0] wide_acc;
    logic [WIDE_W-1:0] nxt;
    logic [ACC_W-1:0]  sat;

    // acc*10 as shift-add; 4 extra bits cover the worst case without wrap
    assign wide_acc = {4'd0, acc};
    assign nxt      = (wide_acc << 3) + (wide_acc << 1)
                    + {{ACC_W{1'b0}}, digit};
    assign sat      = (nxt > {4'd0, max}) ? max : nxt[ACC_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc   <= '0;
            count <= '0;
        end else if (digit_valid) begin
            acc   <= sat;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/awg_cmd_ctrl.sv
// Command sequencer: single-byte waveform select and F/A/P decimal parameter commands.
// Define CMD_TIMEOUT_EN to abandon a partial parameter command after TIMEOUT_CYCLES idle cycles.
module awg_cmd_ctrl
    import awg_cmd_pkg::*;
#(
    parameter int FREQ_W         = 14,
    parameter int AMP_W          = 8,
    parameter int PH_W           = 8,
    parameter int MAX_DIGITS     = 5,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [4:0]        wave_sel,
    output logic [FREQ_W-1:0] freq_word,
    output logic [AMP_W-1:0]  amp,
    output logic [PH_W-1:0]   phase,
    output logic              cfg_update,
    output logic              cmd_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_t state, state_n;
    fld_t   tgt, tgt_n;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] fmax;
    logic [CNT_W-1:0] cnt;

    logic       clr, dv, err, cfg, apply, tmo;
    logic       wave_we;
    logic [4:0] wave_n;

    logic b_wave, b_zero, b_cmd, b_dig, b_cr, b_esc, room;

    assign b_wave = (rx_data >= CH_1) && (rx_data <= CH_4);
    assign b_zero = (rx_data == CH_0);
    assign b_cmd  = (rx_data == CH_F) || (rx_data == CH_A)
                 || (rx_data == CH_P);
    assign b_dig  = is_digit(rx_data);
    assign b_cr   = (rx_data == CH_CR);
    assign b_esc  = (rx_data == CH_ESC);
    assign room   = (cnt != CNT_W'(MAX_DIGITS));
    assign busy   = (state != ST_IDLE);

    always_comb begin
        fmax = '0;
        unique case (tgt)
            FLD_FREQ:  fmax = ACC_W'((64'd1 << FREQ_W) - 64'd1);
            FLD_AMP:   fmax = ACC_W'((64'd1 << AMP_W) - 64'd1);
            FLD_PHASE: fmax = ACC_W'((64'd1 << PH_W) - 64'd1);
            default:   fmax = '0;
        endcase
    end

    awg_dec_accum #(
        .CNT_W(CNT_W)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .digit_valid(dv),
        .digit      (rx_data[3:0]),
        .max        (fmax),
        .acc        (acc),
        .count      (cnt)
    );

`ifdef CMD_TIMEOUT_EN
    logic [31:0] idle_cnt;

    assign tmo = (state == ST_DIGITS) && !rx_valid
              && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || rx_valid || state != ST_DIGITS || tmo) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    wire unused_timeout = (TIMEOUT_CYCLES == 0);
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tgt   <= FLD_FREQ;
        end else begin
            state <= state_n;
            tgt   <= tgt_n;
        end
    end

    always_comb begin
        state_n = state;
        tgt_n   = tgt;
        clr     = 1'b0;
        dv      = 1'b0;
        err     = 1'b0;
        cfg     = 1'b0;
        apply   = 1'b0;
        wave_we = 1'b0;
        wave_n  = wave_sel;

        unique case (state)
            ST_IDLE: ;
            ST_APPLY: begin
                apply   = 1'b1;
                state_n = ST_IDLE;
            end
            ST_DIGITS: begin
                if (tmo) begin
                    err     = 1'b1;
                    state_n = ST_IDLE;
                end else if (rx_valid) begin
                    unique case (1'b1)
                        b_dig && room:  dv = 1'b1;
                        b_cr && cnt != '0: begin
                            cfg     = 1'b1;
                            state_n = ST_APPLY;
                        end
                        b_esc: state_n = ST_IDLE;
                        default: begin
                            err     = 1'b1;
                            state_n = ST_IDLE;
                        end
                    endcase
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // APPLY consumes no byte, so a byte landing there is decoded as in IDLE
        if (rx_valid && (state == ST_IDLE || state == ST_APPLY)) begin
            unique case (1'b1)
                b_wave: begin
                    wave_we = 1'b1;
                    wave_n  = 5'(rx_data - CH_1);
                end
                b_zero: begin
                    wave_we = 1'b1;
                    wave_n  = WAVE_OFF;
                end
                b_cmd: begin
                    clr     = 1'b1;
                    state_n = ST_DIGITS;
                    unique case (1'b1)
                        rx_data == CH_A: tgt_n = FLD_AMP;
                        rx_data == CH_P: tgt_n = FLD_PHASE;
                        default:         tgt_n = FLD_FREQ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wave_sel   <= WAVE_DEF;
            freq_word  <= FREQ_W'(FREQ_DEF);
            amp        <= '1;
            phase      <= '0;
            cfg_update <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            cfg_update <= cfg || wave_we;
            cmd_err    <= err;
            if (wave_we) wave_sel <= wave_n;
            if (apply) begin
                unique case (tgt)
                    FLD_FREQ:  freq_word <= acc[FREQ_W-1:0];
                    FLD_AMP:   amp       <= acc[AMP_W-1:0];
                    FLD_PHASE: phase     <= acc[PH_W-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
